// File: rtl/bcd_seg7_scan.sv
// Eight-digit multiplexed 7-segment driver: double-buffers BCD loads, swaps on
// frame boundaries, scans one digit per slot with a one-cycle dead time.
module bcd_seg7_scan #(
  parameter int unsigned C_SCAN_DIV = 1000
) (
  input  logic        CK_i,
  input  logic        ARST_i,
  input  logic        EN_CK_i,
  input  logic [31:0] BCD_i,
  input  logic        DONE_i,
  input  logic        BLANK_EN_i,
  input  logic [7:0]  DP_i,
  output logic [7:0]  SEG_o,
  output logic [7:0]  DIG_o,
  output logic        FRAME_o
);

  localparam int unsigned PRE_W = $clog2(C_SCAN_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(C_SCAN_DIV - 1);

  logic [31:0]      shadow;
  logic [31:0]      disp;
  logic             pend;
  logic [PRE_W-1:0] pre;
  logic [2:0]       idx;

  logic             slot_end_c;
  logic             frame_end_c;
  logic [3:0]       cur_digit_c;
  logic [7:0]       blank_mask_c;
  logic [6:0]       seg_body_c;
  logic [7:0]       seg_nxt_c;
  logic [7:0]       dig_nxt_c;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h40;
    endcase
  endfunction

  assign slot_end_c  = (pre == PRE_LAST);
  assign frame_end_c = slot_end_c && (idx == 3'd7);
  assign cur_digit_c = disp[{idx, 2'b00} +: 4];

  // A digit is blankable when it and every more significant digit are zero
  always_comb begin
    logic run;
    run          = 1'b1;
    blank_mask_c = 8'h00;
    for (int k = 7; k >= 0; k--) begin
      run             = run && (disp[4*k +: 4] == 4'd0);
      blank_mask_c[k] = run;
    end
    blank_mask_c[0] = 1'b0;
  end

  always_comb begin
    seg_body_c = (BLANK_EN_i && blank_mask_c[idx]) ? 7'h00 : seg7(cur_digit_c);
    seg_nxt_c  = (pre == '0) ? 8'h00 : {DP_i[idx], seg_body_c};
    dig_nxt_c  = (pre == '0) ? 8'h00 : 8'(8'd1 << idx);
  end

  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      shadow  <= '0;
      disp    <= '0;
      pend    <= 1'b0;
      pre     <= '0;
      idx     <= '0;
      SEG_o   <= '0;
      DIG_o   <= '0;
      FRAME_o <= 1'b0;
    end else if (EN_CK_i) begin
      SEG_o   <= seg_nxt_c;
      DIG_o   <= dig_nxt_c;
      FRAME_o <= frame_end_c;
      pre     <= slot_end_c ? '0 : pre + 1'b1;
      if (slot_end_c) idx <= idx + 3'd1;
      if (DONE_i) shadow <= BCD_i;
      // Swap uses the pre-edge shadow; a coincident load stays pending
      if (frame_end_c && pend) disp <= shadow;
      if (DONE_i) pend <= 1'b1;
      else if (frame_end_c) pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Directed bench for bcd_seg7_scan with C_SCAN_DIV=4 (32-cycle frames).
module tb_bcd_seg7_scan;

  logic        CK_i = 1'b0;
  logic        ARST_i = 1'b0;
  logic        EN_CK_i = 1'b1;
  logic [31:0] BCD_i = '0;
  logic        DONE_i = 1'b0;
  logic        BLANK_EN_i = 1'b0;
  logic [7:0]  DP_i = '0;
  logic [7:0]  SEG_o;
  logic [7:0]  DIG_o;
  logic        FRAME_o;

  int total = 0;
  int passed = 0;
  int fails = 0;

  bcd_seg7_scan #(.C_SCAN_DIV(4)) dut (
    .CK_i(CK_i), .ARST_i(ARST_i), .EN_CK_i(EN_CK_i), .BCD_i(BCD_i),
    .DONE_i(DONE_i), .BLANK_EN_i(BLANK_EN_i), .DP_i(DP_i),
    .SEG_o(SEG_o), .DIG_o(DIG_o), .FRAME_o(FRAME_o)
  );

  always #5 CK_i = ~CK_i;

  task automatic tick();
    @(posedge CK_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] seg, input logic [7:0] dig,
                            input logic frame);
    check({tag, " seg"}, 32'(SEG_o), 32'(seg));
    check({tag, " dig"}, 32'(DIG_o), 32'(dig));
    check({tag, " frame"}, 32'(FRAME_o), 32'(frame));
  endtask

  // One full frame starting at PRE=0, IDX=0; exp_seg byte i is slot i's segments
  task automatic run_frame(input string tag, input logic [63:0] exp_seg,
                           input int ld1_at, input logic [31:0] ld1,
                           input int ld2_at, input logic [31:0] ld2);
    logic [7:0] exp_dig;
    for (int s = 0; s < 32; s++) begin
      DONE_i = (s == ld1_at) || (s == ld2_at);
      BCD_i  = (s == ld2_at) ? ld2 : ld1;
      tick();
      DONE_i = 1'b0;
      exp_dig = 8'd1 << (s / 4);
      if (s % 4 == 0)
        check($sformatf("%s s%0d dead", tag, s), 32'(DIG_o), 32'h0);
      if (s % 4 == 2) begin
        check($sformatf("%s s%0d dig", tag, s), 32'(DIG_o), 32'(exp_dig));
        check($sformatf("%s s%0d seg", tag, s), 32'(SEG_o), 32'(exp_seg[8*(s/4) +: 8]));
      end
      if (s == 0)
        check($sformatf("%s frame_lo", tag), 32'(FRAME_o), 32'h0);
      if (s == 31)
        check($sformatf("%s frame_hi", tag), 32'(FRAME_o), 32'h1);
    end
  endtask

  initial begin
    #2 ARST_i = 1'b1;
    #2 check_outs("reset", 8'h00, 8'h00, 1'b0);
    tick();
    tick();
    ARST_i = 1'b0;

    // Plain scan of an all-zero display
    run_frame("scan0", {8{8'h3F}}, -1, '0, -1, '0);
    run_frame("ld12345678", {8{8'h3F}}, 5, 32'h12345678, -1, '0);
    run_frame("show12345678", 64'h065B4F666D7D077F, 10, 32'h00000105, -1, '0);

    BLANK_EN_i = 1'b1;
    DP_i       = 8'h04;
    run_frame("blank105", 64'h0000000000863F6D, 3, 32'h0000000A, -1, '0);

    DP_i = 8'h00;
    run_frame("dashA", 64'h0000000000000040, 4, 32'h11111111, 20, 32'h22222222);

    BLANK_EN_i = 1'b0;
    run_frame("last_load", {8{8'h5B}}, 31, 32'h33333333, -1, '0);
    run_frame("edge_nopend", {8{8'h5B}}, -1, '0, -1, '0);
    run_frame("show33", {8{8'h4F}}, 8, 32'h44444444, 31, 32'h55555555);
    run_frame("edge_pend", {8{8'h66}}, -1, '0, -1, '0);
    run_frame("show55", {8{8'h6D}}, -1, '0, -1, '0);

    // Pending load, clock-enable hold, then mid-slot reset
    DONE_i = 1'b1;
    BCD_i  = 32'h77777777;
    tick();
    DONE_i = 1'b0;
    tick();
    tick();
    check_outs("pre_hold", 8'h6D, 8'h01, 1'b0);
    EN_CK_i = 1'b0;
    for (int h = 0; h < 3; h++) begin
      DONE_i = 1'b1;
      BCD_i  = 32'h99999999;
      tick();
      check_outs($sformatf("hold%0d", h), 8'h6D, 8'h01, 1'b0);
    end
    DONE_i  = 1'b0;
    EN_CK_i = 1'b1;
    tick();
    check_outs("resume_s3", 8'h6D, 8'h01, 1'b0);
    tick();
    check_outs("resume_dead", 8'h00, 8'h00, 1'b0);
    tick();
    check_outs("resume_s1", 8'h6D, 8'h02, 1'b0);
    #2 ARST_i = 1'b1;
    #1 check_outs("arst_async", 8'h00, 8'h00, 1'b0);
    for (int h = 0; h < 4; h++) begin
      EN_CK_i = h[0];
      tick();
      check_outs($sformatf("arst_held%0d", h), 8'h00, 8'h00, 1'b0);
    end
    EN_CK_i = 1'b1;
    ARST_i  = 1'b0;
    run_frame("post_rst", {8{8'h3F}}, -1, '0, -1, '0);
    run_frame("no_stale", {8{8'h3F}}, -1, '0, -1, '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bcd_seg7_scan.md
BCD_SEG7_SCAN -- requirements
Module: bcd_seg7_scan

Interface
REQ-001 SHALL have parameter C_SCAN_DIV, default 1000, clock-enabled cycles per digit slot; legal range 2..65535.
REQ-002 SHALL have port CK_i  input  1  single clock; all state rises on CK_i.
REQ-003 SHALL have port ARST_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port EN_CK_i  input  1  clock enable; when low, all state holds and DONE_i is ignored.
REQ-005 SHALL have port BCD_i  input  32  8 BCD digits; digit k is BCD_i[4k+3:4k], digit 0 least significant.
REQ-006 SHALL have port DONE_i  input  1  one-cycle load strobe from the upstream BCD converter.
REQ-007 SHALL have port BLANK_EN_i  input  1  leading-zero blanking enable.
REQ-008 SHALL have port DP_i  input  8  decimal point per digit; bit k belongs to digit k.
REQ-009 SHALL have port SEG_o  output  8  segments {dp,g,f,e,d,c,b,a}, active-high, registered.
REQ-010 SHALL have port DIG_o  output  8  digit select, one-hot or all-zero, active-high, registered.
REQ-011 SHALL have port FRAME_o  output  1  one-cycle pulse at each frame boundary, registered.

Function
REQ-012 SHALL hold SHADOW (32b), PEND (1b), DISP (32b), PRE (prescaler, 0..C_SCAN_DIV-1) and IDX (3b digit index).
REQ-013 SHALL, on an EN_CK_i cycle with DONE_i=1, load SHADOW<=BCD_i and set PEND<=1.
REQ-014 SHALL, on every EN_CK_i cycle, increment PRE; at PRE==C_SCAN_DIV-1, set PRE<=0 and IDX<=IDX+1 mod 8 (slot end).
REQ-015 SHALL define the frame boundary as a slot end with IDX==7; on it, FRAME_o<=1 for exactly one EN cycle, and if PEND==1 then DISP<=SHADOW and PEND<=0.
REQ-016 SHALL, when DONE_i coincides with a frame boundary, copy the pre-edge SHADOW into DISP, load BCD_i into SHADOW, and leave PEND=1, so the new value appears one frame later.
REQ-017 SHALL, when DONE_i occurs more than once within a frame, display only the last loaded value; earlier values are discarded without error.
REQ-018 SHALL drive DIG_o from the registered decode of the current PRE and IDX, with one EN-cycle latency: all-zero when PRE==0 (one-cycle anti-ghost dead time), otherwise bit IDX set.
REQ-019 SHALL drive SEG_o[6:0] from the registered decode of DISP digit IDX, with the same one-cycle latency: 0->3F 1->06 2->5B 3->4F 4->66 5->6D 6->7D 7->07 8->7F 9->6F; values A..F->40 (dash).
REQ-020 SHALL, with BLANK_EN_i=1, force SEG_o[6:0]=00 for digit k when digits k..7 of DISP are all zero; digit 0 is never blanked.
REQ-021 SHALL set SEG_o[7]=DP_i[IDX], unaffected by blanking.
REQ-022 SHALL drive SEG_o=00 whenever DIG_o is all-zero.
REQ-023 SHALL evaluate BLANK_EN_i and DP_i live, not latched with DONE_i.
REQ-024 SHALL hold every register, including FRAME_o, while EN_CK_i=0.

Reset
REQ-025 SHALL, while ARST_i=1, clear SHADOW, DISP, PEND, PRE, IDX, SEG_o, DIG_o and FRAME_o to 0, independent of CK_i and EN_CK_i.
REQ-026 SHALL, on ARST_i asserted mid-frame, discard any pending load; scan restarts at IDX=0, PRE=0 after release.

Verification
REQ-027 SHALL cover: with C_SCAN_DIV=4 and EN_CK_i=1, release reset -> DIG_o=00 for cycle 1, then 01 for 3 cycles with SEG_o=3F, then 00 once, then 02, and so on; FRAME_o pulses every 32 cycles.
REQ-028 SHALL cover: BCD_i=32'h12345678 with DONE_i and BLANK_EN_i=0 -> after the next frame boundary, slot 0 SEG_o=7F, slot 7 SEG_o=06; before that boundary all slots show 3F.
REQ-029 SHALL cover: BCD_i=32'h00000105 with BLANK_EN_i=1 and DP_i=8'h04 -> slots 0,1,2 show 6D, 3F, 86; slots 3..7 show 00 with DIG_o still asserted.
REQ-030 SHALL cover: BCD_i=32'h0000000A -> slot 0 SEG_o=40; slots 1..7 with BLANK_EN_i=1 show 00.
REQ-031 SHALL cover: DONE_i with 32'h11111111 then 32'h22222222 in one frame -> only 5B shown; DONE_i on the boundary edge -> value shown one frame later.
REQ-032 SHALL cover: ARST_i pulse mid-slot, with a pending load and EN_CK_i toggling -> all outputs 0 immediately; the pending value is never displayed; scan holds on EN_CK_i=0 cycles.
